// File: rtl/sized_data_memory_pkg.sv
// Shared types for sized_data_memory: access-size encoding and byte-count helper.
// Pure declarations; no latency or backpressure of its own.
package sized_data_memory_pkg;

  localparam int DATA_WIDTH_FIXED = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  // The illegal encoding reports 4 so range math stays defined; it is flagged separately.
  function automatic logic [2:0] size_bytes(input mem_size_t size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sized_data_memory_if.sv
// Request/response bundle for sized_data_memory; slave = memory side, master = LSU side.
// Valid/ready on both channels; no storage in the interface itself.
interface sized_data_memory_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_write_i;
  logic [1:0]               req_size_i;
  logic                     req_unsigned_i;
  logic [ADDRESS_WIDTH-1:0] address_i;
  logic [DATA_WIDTH-1:0]    write_data_i;
  logic                     resp_valid_o;
  logic                     resp_ready_i;
  logic [DATA_WIDTH-1:0]    read_value_o;
  logic                     resp_error_o;

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, address_i, write_data_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, read_value_o, resp_error_o
  );

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i, address_i, write_data_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, read_value_o, resp_error_o
  );
endinterface

// File: rtl/sized_data_memory_extend.sv
// mem_load_extend: selects the addressed byte/half of a little-endian word and extends it.
// Purely combinational, no backpressure.
module mem_load_extend
  import sized_data_memory_pkg::*;
(
  input  logic [31:0] raw_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = raw_i[{offset_i, 3'b000} +: 8];
    half_v  = raw_i[{offset_i[1], 4'b0000} +: 16];
    value_o = raw_i;
    case (size_i)
      SIZE_BYTE: value_o = {{24{!unsigned_i && byte_v[7]}}, byte_v};
      SIZE_HALF: value_o = {{16{!unsigned_i && half_v[15]}}, half_v};
      default:   value_o = raw_i;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressable data RAM with sized loads/stores; response registered 1 cycle after accept.
// Single-entry output stage: req_ready_o drops while a response is held; SIZED_DATA_MEMORY_PERF_EN adds counters.
module sized_data_memory
  import sized_data_memory_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH_BYTES   = 131072,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter string                    INIT_FILE     = ""
)(
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef SIZED_DATA_MEMORY_PERF_EN
  output logic [31:0]         load_count_o,
  output logic [31:0]         store_count_o,
  output logic [31:0]         error_count_o,
`endif
  sized_data_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  if (DATA_WIDTH != DATA_WIDTH_FIXED) begin : g_bad_width
    $error("sized_data_memory: DATA_WIDTH must be 32");
  end
  if ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0 || (DEPTH_BYTES % 4) != 0) begin : g_bad_depth
    $error("sized_data_memory: DEPTH_BYTES must be a power of two and a multiple of 4");
  end
  if ((BASE_ADDR & ADDRESS_WIDTH'(DEPTH_BYTES - 1)) != '0) begin : g_bad_base
    $error("sized_data_memory: BASE_ADDR must be DEPTH_BYTES-aligned");
  end

  logic [7:0] mem [DEPTH_BYTES];

  mem_size_t                size;
  logic [2:0]               nbytes;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [ADDRESS_WIDTH:0]   end_addr;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         wbase;
  logic                     shape_err;
  logic                     in_range;
  logic                     req_err;
  logic                     accept;
  logic [31:0]              raw_word;
  logic [31:0]              ext_value;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] read_value_q, read_value_d;

  assign bus.req_ready_o = !rst_i && (!resp_valid_q || bus.resp_ready_i);
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  always_comb begin
    size     = mem_size_t'(bus.req_size_i);
    nbytes   = size_bytes(size);
    offset   = bus.address_i - BASE_ADDR;
    // One extra bit keeps offset+size from wrapping near the top of the address space.
    end_addr = {1'b0, offset} + (ADDRESS_WIDTH + 1)'(nbytes);
    in_range = (bus.address_i >= BASE_ADDR) &&
               (end_addr <= (ADDRESS_WIDTH + 1)'(DEPTH_BYTES));
    case (size)
      SIZE_BYTE: shape_err = 1'b0;
      SIZE_HALF: shape_err = bus.address_i[0];
      SIZE_WORD: shape_err = (bus.address_i[1:0] != 2'b00);
      default:   shape_err = 1'b1;
    endcase
    req_err  = shape_err || !in_range;
    idx      = offset[IDX_W-1:0];
    wbase    = {idx[IDX_W-1:2], 2'b00};
    raw_word = {mem[wbase + IDX_W'(3)], mem[wbase + IDX_W'(2)],
                mem[wbase + IDX_W'(1)], mem[wbase]};
  end

  mem_load_extend u_extend (
    .raw_i      (raw_word),
    .size_i     (size),
    .unsigned_i (bus.req_unsigned_i),
    .offset_i   (offset[1:0]),
    .value_o    (ext_value)
  );

  // accept is already gated by rst_i, so a store on a reset edge never lands.
  always_ff @(posedge clk_i) begin
    if (accept && bus.req_write_i && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) mem[idx + IDX_W'(k)] <= bus.write_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    read_value_d = read_value_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_error_d = req_err;
      read_value_d = (req_err || bus.req_write_i) ? 32'h0 : ext_value;
    end else if (bus.resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      read_value_q <= 32'h0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      read_value_q <= read_value_d;
    end
  end

  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_error_o = resp_error_q;
  assign bus.read_value_o = read_value_q;

`ifdef SIZED_DATA_MEMORY_PERF_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  logic [31:0] error_cnt_q, error_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    error_cnt_d = error_cnt_q;
    if (accept) begin
      if (req_err) begin
        if (error_cnt_q != '1) error_cnt_d = error_cnt_q + 32'd1;
      end else if (bus.req_write_i) begin
        if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 32'd1;
      end else begin
        if (load_cnt_q != '1) load_cnt_d = load_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      error_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      error_cnt_q <= error_cnt_d;
    end
  end

  assign load_count_o  = load_cnt_q;
  assign store_count_o = store_cnt_q;
  assign error_count_o = error_cnt_q;
`endif

endmodule
